palette_loader: RTL

Sequences writes of a user-supplied 64-entry RGB palette into the video block's loadable palette RAM. It assembles a byte-serial download into 24-bit colours and buffers them in a small FIFO. Each colour is committed through the `load_color`/`load_color_data`/`load_color_index` port only while the picture is blanked, so a download never corrupts visible pixels. It sits between the download/ioctl path and the video palette RAM.

---
 rtl/palette_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/palette_loader.sv
// palette_loader: assembles byte-serial RGB downloads into 24-bit colours
// and commits them to the video palette RAM during blanking.
module palette_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_start,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        blank,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        pal_loaded,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    ARM,
    WRITE,
    RECOVER
  } state_t;

  state_t state, state_nx;

  logic [29:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    lane;
  logic [6:0]    entry;
  logic [7:0]    r_q;
  logic [7:0]    g_q;

  logic full;
  logic nempty;
  logic go;
  logic wr_acc;
  logic lane2;
  logic push;
  logic drop;
  logic [29:0] head;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign nempty  = (count != '0);
  assign dl_wait = full;
  assign head    = mem[rd_ptr];

  // bytes past entry 64 are silently ignored
  assign wr_acc = dl_wr & ~dl_start & ~entry[6];
  assign lane2  = wr_acc & (lane == 2'd2);
  assign push   = lane2 & (~full | go);
  assign drop   = lane2 & full & ~go;

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      EMPTY: begin
        if (!dl_start && nempty)
          state_nx = ARM;
      end
      ARM: begin
        if (dl_start) begin
          state_nx = EMPTY;
        end else if (blank || !BLANK_ONLY) begin
          go       = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        state_nx = RECOVER;
      end
      RECOVER: begin
        if (!dl_start && nempty)
          state_nx = ARM;
        else
          state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= EMPTY;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {r_q, g_q, dl_data, entry[5:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (dl_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (go)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(go);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane  <= 2'd0;
      entry <= 7'd0;
      r_q   <= 8'd0;
      g_q   <= 8'd0;
    end else if (dl_start) begin
      lane  <= 2'd0;
      entry <= 7'd0;
    end else if (wr_acc) begin
      unique case (1'b1)
        lane == 2'd0: begin
          r_q  <= dl_data;
          lane <= 2'd1;
        end
        lane == 2'd1: begin
          g_q  <= dl_data;
          lane <= 2'd2;
        end
        default: begin
          lane  <= 2'd0;
          entry <= entry + 7'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_color       <= 1'b0;
      load_color_data  <= 24'd0;
      load_color_index <= 6'd0;
    end else begin
      load_color <= go;
      if (go) begin
        load_color_data  <= head[29:6];
        load_color_index <= head[5:0];
      end
    end
  end

  // a single dropped entry disqualifies the whole download
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else if (dl_start) begin
      pal_loaded <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      if (state == WRITE && load_color_index == 6'd63 &&
          !overflow && !drop)
        pal_loaded <= 1'b1;
    end
  end

endmodule
